// File: rtl/snow64_memory_bus_guard_if.sv
// Bus bundle between the read/write FIFO requesters, the memory bus guard and memory.
// The guard uses the master view; requesters and memory together use the slave view.
interface snow64_memory_bus_guard_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_cmd_accepted;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_cmd_accepted;
  logic                  wr_valid;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_cmd_ready;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  logic                  busy;
  logic                  err_timeout;
  logic                  err_spurious;

  modport master (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    output rd_cmd_accepted, rd_valid, rd_data, wr_cmd_accepted, wr_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, err_timeout, err_spurious
  );

  modport slave (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    input  rd_cmd_accepted, rd_valid, rd_data, wr_cmd_accepted, wr_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, err_timeout, err_spurious
  );
endinterface

// File: rtl/snow64_memory_bus_guard.sv
// Arbitrates one read and one write FIFO onto a single-outstanding memory bus,
// with round-robin tie-break, response timeout and spurious-response detection.
module snow64_memory_bus_guard #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  snow64_memory_bus_guard_if.master     bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int             CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [1:0]            state_q,     state_d;
  logic                  last_we_q,   last_we_d;
  logic                  grant_we_q,  grant_we_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  rd_acc_q,    rd_acc_d;
  logic                  wr_acc_q,    wr_acc_d;
  logic                  rd_valid_q,  rd_valid_d;
  logic                  wr_valid_q,  wr_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic                  err_to_q,    err_to_d;
  logic                  err_sp_q,    err_sp_d;

  logic                  grant_rd;
  logic [CNT_W-1:0]      cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    last_we_d  = last_we_q;
    grant_we_d = grant_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rd_acc_d   = 1'b0;
    wr_acc_d   = 1'b0;
    rd_valid_d = 1'b0;
    wr_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_to_d   = err_to_q;
    err_sp_d   = err_sp_q;
    grant_rd   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rd_req || bus.wr_req) begin
          // On a tie the side that did not complete last wins.
          grant_rd   = bus.rd_req && (!bus.wr_req || last_we_q);
          grant_we_d = !grant_rd;
          addr_d     = grant_rd ? bus.rd_addr : bus.wr_addr;
          if (!grant_rd) begin
            wdata_d = bus.wr_data;
          end
          rd_acc_d = grant_rd;
          wr_acc_d = !grant_rd;
          state_d  = ST_CMD;
        end
      end

      ST_CMD: begin
        if (bus.mem_cmd_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A response arriving on the timeout cycle still completes normally.
        if (bus.mem_rsp_valid) begin
          rd_valid_d = !grant_we_q;
          wr_valid_d = grant_we_q;
          if (!grant_we_q) begin
            rd_data_d = bus.mem_rsp_data;
          end
          last_we_d = grant_we_q;
          state_d   = ST_IDLE;
        end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT)) begin
          rd_valid_d = !grant_we_q;
          wr_valid_d = grant_we_q;
          if (!grant_we_q) begin
            rd_data_d = '0;
          end
          err_to_d  = 1'b1;
          last_we_d = grant_we_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.mem_rsp_valid && (state_q != ST_WAIT)) begin
      err_sp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      // NOTE: datapath latches are reset too, because they drive outputs that must read 0 in reset.
      state_q    <= ST_IDLE;
      last_we_q  <= 1'b1;
      grant_we_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rd_acc_q   <= 1'b0;
      wr_acc_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_to_q   <= 1'b0;
      err_sp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_we_q  <= last_we_d;
      grant_we_q <= grant_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rd_acc_q   <= rd_acc_d;
      wr_acc_q   <= wr_acc_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_data_q  <= rd_data_d;
      err_to_q   <= err_to_d;
      err_sp_q   <= err_sp_d;
    end
  end

  assign bus.rd_cmd_accepted = rd_acc_q;
  assign bus.wr_cmd_accepted = wr_acc_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.wr_valid        = wr_valid_q;
  assign bus.rd_data         = rd_data_q;

  assign bus.mem_req         = (state_q == ST_CMD);
  assign bus.mem_we          = grant_we_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = wdata_q;

  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.err_timeout     = err_to_q;
  assign bus.err_spurious    = err_sp_q;

endmodule

// File: doc/snow64_memory_bus_guard.md
SNOW64_MEMORY_BUS_GUARD -- requirements
Module: snow64_memory_bus_guard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 64, CPU address width.
- DATA_WIDTH, 256, LAR data width.
- TIMEOUT, 255, max WAIT_RSP cycles before abort; 0 disables timeout.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_req  in  1  read FIFO command request.
- rd_addr  in  ADDR_WIDTH  read address, DATA_WIDTH-aligned.
- rd_cmd_accepted  out  1  one-cycle pulse: read command captured.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  DATA_WIDTH  read response data.
- wr_req  in  1  write FIFO command request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_cmd_accepted  out  1  one-cycle pulse: write command captured.
- wr_valid  out  1  one-cycle pulse: write completed.
- mem_req  out  1  memory command valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_cmd_ready  in  1  memory accepts command this cycle.
- mem_rsp_valid  in  1  memory response this cycle.
- mem_rsp_data  in  DATA_WIDTH  memory read data.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky: response timeout occurred.
- err_spurious  out  1  sticky: mem_rsp_valid outside WAIT_RSP.

Function
REQ-003 FSM states SHALL be IDLE, CMD, WAIT_RSP; exactly one memory transaction outstanding.
REQ-004 In IDLE with only one req high, that requester SHALL be granted at the clock edge.
REQ-005 In IDLE with both reqs high, grant SHALL go to the requester not in last_grant (round-robin).
REQ-006 On grant: latch addr (and wr_data for writes), set grant_we, enter CMD, pulse the matching *_cmd_accepted for the following cycle only.
REQ-007 Requesters SHALL deassert req in the cycle *_cmd_accepted is seen; req is ignored outside IDLE.
REQ-008 In CMD: mem_req=1, mem_we=grant_we, mem_addr and mem_wdata from latches, all held stable until mem_cmd_ready=1; then enter WAIT_RSP.
REQ-009 mem_req SHALL be 0 in IDLE and WAIT_RSP; mem_we/mem_addr/mem_wdata are don't-care when mem_req=0.
REQ-010 In WAIT_RSP, on mem_rsp_valid=1: read grants latch rd_data=mem_rsp_data and pulse rd_valid next cycle; write grants pulse wr_valid next cycle; mem_rsp_data ignored for writes; last_grant updated; enter IDLE.
REQ-011 Minimum latency SHALL be req-to-cmd_accepted 1 cycle, CMD at least 1 cycle, rsp-to-valid 1 cycle; back-to-back grant allowed in the cycle after returning to IDLE.
REQ-012 rd_data SHALL hold its value until the next read response or timeout.
REQ-013 A wait counter SHALL clear on WAIT_RSP entry and increment each WAIT_RSP cycle; if TIMEOUT!=0 and it reaches TIMEOUT without mem_rsp_valid, set err_timeout, pulse the granted *_valid (rd_data=0 for reads), update last_grant, enter IDLE.
REQ-014 mem_rsp_valid in IDLE or CMD SHALL set err_spurious and change no other state.
REQ-015 mem_rsp_valid in the same cycle the timeout count is reached SHALL complete normally; err_timeout stays unchanged.

Reset
REQ-016 rst_n=0 at a rising edge SHALL force state=IDLE, last_grant=write (read wins the first tie), counter=0, and every output (including rd_data, err_timeout, err_spurious) to 0, aborting any transaction in flight without a valid pulse.
REQ-017 After reset deassertion, grant SHALL be possible on the first edge with rst_n=1.

Verification
REQ-018 The bench SHALL cover:
- Single read: rd_req, rd_addr=0x40, mem_cmd_ready immediate, rsp 3 cycles later, data 0xA5.. -> cmd_accepted at cycle 1, mem_req cycle 1 only, rd_valid cycle 5 with data.
- Simultaneous rd_req/wr_req after reset, repeated -> order read, write, read, write; wr_addr/wr_data on mem bus with mem_we=1.
- mem_cmd_ready held 0 for 4 cycles -> mem_req/addr/wdata stable for 5 cycles, no valid pulse.
- TIMEOUT=4, no response -> err_timeout=1 after 4 WAIT_RSP cycles, rd_valid pulse with rd_data=0, busy=0 afterwards.
- mem_rsp_valid pulsed in IDLE -> err_spurious=1, no valid pulses, busy=0.
- rst_n=0 during WAIT_RSP -> all outputs 0 next cycle, a late response sets err_spurious only.
